// File: rtl/mcycle_ctrl.sv
// Multicycle control unit: fetch/decode/operand/execute/memory/branch sequencer with start/busy/done handshake.
// Optional memory wait states are enabled by defining CTRL_MEM_HANDSHAKE_EN.
module mcycle_ctrl #(
    parameter int IW   = 8,
    parameter int ALUW = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [IW-1:0]       instr,
    input  logic                z_flag,
    input  logic                mem_ack,
    output logic                busy,
    output logic                done,
    output logic                pci,
    output logic [IW/2-1:0]     rst_sel,
    output logic [IW/2-1:0]     a_sel,
    output logic [IW/2-1:0]     b_sel,
    output logic [IW/2-1:0]     c_sel,
    output logic [ALUW-1:0]     alu_op,
    output logic [1:0]          mem_op,
    output logic                mem_req,
    output logic                ir_en,
    output logic                branch,
    output logic [1:0]          mux2_ctrl,
    output logic [3:0]          state
);
    localparam int RSELW = IW / 2;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_OPND = 4'd3,
        S_EXEC = 4'd4, S_MEM   = 4'd5, S_BRANCH = 4'd6, S_HALT = 4'd7
    } state_t;

    // Bus selects are registered as a source code; the field itself comes from the IR,
    // because the second instruction word only lands in the IR as EXEC begins.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0, SRC_LO = 2'd1, SRC_HI = 2'd2, SRC_ONES = 2'd3
    } src_t;

    localparam logic [RSELW-1:0] OP_NOOP  = RSELW'(4'h0);
    localparam logic [RSELW-1:0] OP_CLR   = RSELW'(4'h1);
    localparam logic [RSELW-1:0] OP_LOAD  = RSELW'(4'h2);
    localparam logic [RSELW-1:0] OP_STORE = RSELW'(4'h3);
    localparam logic [RSELW-1:0] OP_COPY  = RSELW'(4'h4);
    localparam logic [RSELW-1:0] OP_INCR  = RSELW'(4'h5);
    localparam logic [RSELW-1:0] OP_ADDI  = RSELW'(4'h6);
    localparam logic [RSELW-1:0] OP_ADDR  = RSELW'(4'h7);
    localparam logic [RSELW-1:0] OP_SUBI  = RSELW'(4'h8);
    localparam logic [RSELW-1:0] OP_SUBR  = RSELW'(4'h9);
    localparam logic [RSELW-1:0] OP_SHL   = RSELW'(4'hA);
    localparam logic [RSELW-1:0] OP_SHR   = RSELW'(4'hB);
    localparam logic [RSELW-1:0] OP_JPNZ  = RSELW'(4'hC);
    localparam logic [RSELW-1:0] OP_OR    = RSELW'(4'hD);
    localparam logic [RSELW-1:0] OP_JPZ   = RSELW'(4'hE);
    localparam logic [RSELW-1:0] OP_END   = RSELW'(4'hF);

    function automatic logic is_two_word(input logic [RSELW-1:0] op);
        return (op == OP_COPY) || (op == OP_ADDI) || (op == OP_ADDR) || (op == OP_SUBI) ||
               (op == OP_SUBR) || (op == OP_SHL)  || (op == OP_SHR)  || (op == OP_OR);
    endfunction

    function automatic logic [RSELW-1:0] sel_field(input src_t src, input logic [IW-1:0] ir);
        case (src)
            SRC_LO:   return ir[RSELW-1:0];
            SRC_HI:   return ir[IW-1:RSELW];
            SRC_ONES: return {RSELW{1'b1}};
            default:  return {RSELW{1'b0}};
        endcase
    endfunction

    state_t           state_r, state_n;
    logic [RSELW-1:0] op_q_r, opcode_s, op_s;
    logic             advance_s;
    logic             pci_r, pci_n, ir_en_r, ir_n, branch_r, br_n, busy_r, done_r, mem_req_r;
    src_t             rs_src_r, a_src_r, b_src_r, c_src_r, rs_n, a_n, b_n, c_n;
    logic [ALUW-1:0]  alu_r, alu_n;
    logic [1:0]       mem_op_r, mem_n, mux2_r, mux_n;

    assign opcode_s = instr[IW-1:RSELW];
    assign op_s     = (state_r == S_DECODE) ? opcode_s : op_q_r;

`ifdef CTRL_MEM_HANDSHAKE_EN
    assign advance_s = mem_ack;
    assign ir_en     = ir_en_r & mem_ack;
`else
    // mem_ack has no effect without wait states; the OR keeps the port referenced.
    assign advance_s = 1'b1 | mem_ack;
    assign ir_en     = ir_en_r;
`endif

    // State and registered Moore outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            op_q_r    <= {RSELW{1'b0}};
            pci_r     <= 1'b0;
            rs_src_r  <= SRC_NONE;
            a_src_r   <= SRC_NONE;
            b_src_r   <= SRC_NONE;
            c_src_r   <= SRC_NONE;
            alu_r     <= {ALUW{1'b0}};
            mem_op_r  <= 2'b00;
            mem_req_r <= 1'b0;
            ir_en_r   <= 1'b0;
            branch_r  <= 1'b0;
            mux2_r    <= 2'b00;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_n;
            op_q_r    <= op_s;
            pci_r     <= pci_n;
            rs_src_r  <= rs_n;
            a_src_r   <= a_n;
            b_src_r   <= b_n;
            c_src_r   <= c_n;
            alu_r     <= alu_n;
            mem_op_r  <= mem_n;
            mem_req_r <= (mem_n != 2'b00);
            ir_en_r   <= ir_n;
            branch_r  <= br_n;
            mux2_r    <= mux_n;
            busy_r    <= (state_n != S_IDLE) && (state_n != S_HALT);
            done_r    <= (state_n == S_HALT);
        end
    end

    // Next-state selection.
    always_comb begin
        state_n = state_r;
        case (state_r)
            S_IDLE, S_HALT: state_n = start ? S_FETCH : state_r;
            S_FETCH:        state_n = advance_s ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_two_word(opcode_s)) begin
                    state_n = S_OPND;
                end else begin
                    case (opcode_s)
                        OP_CLR, OP_INCR, OP_NOOP: state_n = S_EXEC;
                        OP_LOAD, OP_STORE:        state_n = S_MEM;
                        OP_JPNZ:                  state_n = z_flag ? S_FETCH : S_BRANCH;
                        OP_JPZ:                   state_n = z_flag ? S_BRANCH : S_FETCH;
                        OP_END:                   state_n = S_HALT;
                        default:                  state_n = S_FETCH;
                    endcase
                end
            end
            S_OPND:   state_n = advance_s ? S_EXEC : S_OPND;
            S_EXEC:   state_n = S_FETCH;
            S_MEM:    state_n = advance_s ? S_FETCH : S_MEM;
            S_BRANCH: state_n = S_FETCH;
            default:  state_n = S_IDLE;
        endcase
    end

    // Output decode of the state about to be entered.
    always_comb begin
        pci_n = 1'b0;
        rs_n  = SRC_NONE;
        a_n   = SRC_NONE;
        b_n   = SRC_NONE;
        c_n   = SRC_NONE;
        alu_n = {ALUW{1'b0}};
        mem_n = 2'b00;
        ir_n  = 1'b0;
        br_n  = 1'b0;
        mux_n = 2'b00;
        case (state_n)
            S_FETCH, S_OPND: begin
                mem_n = 2'b01;
                ir_n  = 1'b1;
            end
            S_DECODE: pci_n = 1'b1;
            S_EXEC: begin
                pci_n = is_two_word(op_s);
                case (op_s)
                    OP_CLR:  rs_n = SRC_LO;
                    OP_INCR: begin a_n = SRC_LO; c_n = SRC_LO; alu_n = ALUW'(4'd2); end
                    OP_COPY: begin a_n = SRC_LO; c_n = SRC_HI; alu_n = ALUW'(4'd1); end
                    OP_ADDI, OP_SUBI: begin
                        a_n   = SRC_HI;
                        c_n   = SRC_HI;
                        b_n   = SRC_ONES;
                        mux_n = 2'b01;
                        alu_n = (op_s == OP_ADDI) ? ALUW'(4'd3) : ALUW'(4'd5);
                    end
                    OP_ADDR, OP_SUBR, OP_OR: begin
                        a_n   = SRC_HI;
                        c_n   = SRC_HI;
                        b_n   = SRC_LO;
                        alu_n = (op_s == OP_ADDR) ? ALUW'(4'd4) :
                                (op_s == OP_SUBR) ? ALUW'(4'd6) : ALUW'(4'd9);
                    end
                    OP_SHL, OP_SHR: begin
                        a_n   = SRC_HI;
                        c_n   = SRC_HI;
                        mux_n = 2'b01;
                        alu_n = (op_s == OP_SHL) ? ALUW'(4'd7) : ALUW'(4'd8);
                    end
                    default: begin
                        rs_n = SRC_NONE;
                    end
                endcase
            end
            S_MEM: mem_n = (op_s == OP_STORE) ? 2'b11 : 2'b10;
            S_BRANCH: begin
                a_n   = SRC_LO;
                c_n   = SRC_ONES;
                alu_n = ALUW'(4'd1);
                br_n  = 1'b1;
            end
            default: begin
                pci_n = 1'b0;
            end
        endcase
    end

    assign state     = state_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pci       = pci_r;
    assign rst_sel   = sel_field(rs_src_r, instr);
    assign a_sel     = sel_field(a_src_r, instr);
    assign b_sel     = sel_field(b_src_r, instr);
    assign c_sel     = sel_field(c_src_r, instr);
    assign alu_op    = alu_r;
    assign mem_op    = mem_op_r;
    assign mem_req   = mem_req_r;
    assign branch    = branch_r;
    assign mux2_ctrl = mux2_r;
endmodule

// File: tb/tb_mcycle_ctrl.sv
// Self-checking bench for mcycle_ctrl: a table of instructions expands into per-cycle expected
// records on a scoreboard queue, plus hand-written HALT/restart, reset and wait-state sequences.
module tb_mcycle_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, start, z_flag, mem_ack;
    logic [7:0] instr;
    logic       busy, done, pci, mem_req, ir_en, branch;
    logic [3:0] rst_sel, a_sel, b_sel, c_sel, alu_op, state;
    logic [1:0] mem_op, mux2_ctrl;

    mcycle_ctrl #(.IW(8), .ALUW(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .z_flag(z_flag),
        .mem_ack(mem_ack), .busy(busy), .done(done), .pci(pci), .rst_sel(rst_sel),
        .a_sel(a_sel), .b_sel(b_sel), .c_sel(c_sel), .alu_op(alu_op), .mem_op(mem_op),
        .mem_req(mem_req), .ir_en(ir_en), .branch(branch), .mux2_ctrl(mux2_ctrl), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       busy, done, pci;
        logic [3:0] rs, a, b, c, alu;
        logic [1:0] mem;
        logic       req, ir, br;
        logic [1:0] mux;
    } out_t;

    typedef struct {
        logic [7:0] w1, w2;
        logic       z, two, has_fin;
        out_t       fin;
    } vec_t;

    typedef struct {
        out_t       exp;
        logic [7:0] drv;
        logic       z, ack;
    } cyc_t;

    cyc_t sbq[$];
    vec_t vt[17];
    int   n_checks = 0;
    int   n_errors = 0;
    out_t act_s;

    assign act_s = {state, busy, done, pci, rst_sel, a_sel, b_sel, c_sel, alu_op,
                    mem_op, mem_req, ir_en, branch, mux2_ctrl};

    function automatic out_t mk(input logic [3:0] st, input logic p, input logic [3:0] rs,
                                input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                                input logic [3:0] alu, input logic [1:0] mem, input logic ir,
                                input logic br, input logic [1:0] mux);
        out_t o;
        o.st = st; o.busy = (st != 4'd0) && (st != 4'd7); o.done = (st == 4'd7);
        o.pci = p; o.rs = rs; o.a = a; o.b = b; o.c = c; o.alu = alu; o.mem = mem;
        o.req = (mem != 2'b00); o.ir = ir; o.br = br; o.mux = mux;
        return o;
    endfunction

    function automatic vec_t mkv(input logic [7:0] w1, input logic [7:0] w2, input logic z,
                                 input logic two, input logic has_fin, input out_t fin);
        vec_t v;
        v.w1 = w1; v.w2 = w2; v.z = z; v.two = two; v.has_fin = has_fin; v.fin = fin;
        return v;
    endfunction

    function automatic out_t o_fetch();  return mk(4'd1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b01, 1'b1, 1'b0, 2'b00); endfunction
    function automatic out_t o_decode(); return mk(4'd2, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 2'b00); endfunction
    function automatic out_t o_opnd();   return mk(4'd3, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b01, 1'b1, 1'b0, 2'b00); endfunction
    function automatic out_t o_zero(input logic [3:0] st);
        return mk(st, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 2'b00);
    endfunction

    task automatic check(input string tag, input out_t exp);
        n_checks++;
        if (act_s !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h required %h (state got %0d req %0d)",
                     tag, $time, act_s, exp, act_s.st, exp.st);
        end
    endtask

    task automatic push(input out_t e, input logic [7:0] d, input logic z, input logic ack);
        cyc_t c;
        c.exp = e; c.drv = d; c.z = z; c.ack = ack;
        sbq.push_back(c);
    endtask

    task automatic push_vec(input vec_t v);
        push(o_fetch(), v.w1, v.z, 1'b1);
        push(o_decode(), v.w1, v.z, 1'b1);
        if (v.two) push(o_opnd(), v.w2, v.z, 1'b1);
        if (v.has_fin) push(v.fin, v.two ? v.w2 : v.w1, v.z, 1'b1);
    endtask

    // Pops one expected record per cycle, compares mid-cycle, then drives that cycle's inputs.
    task automatic run_queue(input string tag);
        cyc_t c;
        while (sbq.size() > 0) begin
            @(negedge clk);
            c = sbq.pop_front();
            check(tag, c.exp);
            instr = c.drv; z_flag = c.z; mem_ack = c.ack;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; instr = 8'h00; z_flag = 1'b0; mem_ack = 1'b1;

        vt[0]  = mkv(8'h03, 8'h00, 1'b0, 1'b0, 1'b1, o_zero(4'd4));
        vt[1]  = mkv(8'h13, 8'h00, 1'b0, 1'b0, 1'b1, mk(4'd4, 1'b0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 2'b00));
        vt[2]  = mkv(8'h24, 8'h00, 1'b0, 1'b0, 1'b1, mk(4'd5, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b10, 1'b0, 1'b0, 2'b00));
        vt[3]  = mkv(8'h35, 8'h00, 1'b0, 1'b0, 1'b1, mk(4'd5, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b11, 1'b0, 1'b0, 2'b00));
        vt[4]  = mkv(8'h40, 8'h16, 1'b0, 1'b1, 1'b1, mk(4'd4, 1'b1, 4'h0, 4'h6, 4'h0, 4'h1, 4'h1, 2'b00, 1'b0, 1'b0, 2'b00));
        vt[5]  = mkv(8'h57, 8'h00, 1'b0, 1'b0, 1'b1, mk(4'd4, 1'b0, 4'h0, 4'h7, 4'h0, 4'h7, 4'h2, 2'b00, 1'b0, 1'b0, 2'b00));
        vt[6]  = mkv(8'h60, 8'h30, 1'b0, 1'b1, 1'b1, mk(4'd4, 1'b1, 4'h0, 4'h3, 4'hF, 4'h3, 4'h3, 2'b00, 1'b0, 1'b0, 2'b01));
        vt[7]  = mkv(8'h73, 8'h25, 1'b0, 1'b1, 1'b1, mk(4'd4, 1'b1, 4'h0, 4'h2, 4'h5, 4'h2, 4'h4, 2'b00, 1'b0, 1'b0, 2'b00));
        vt[8]  = mkv(8'h80, 8'h49, 1'b1, 1'b1, 1'b1, mk(4'd4, 1'b1, 4'h0, 4'h4, 4'hF, 4'h4, 4'h5, 2'b00, 1'b0, 1'b0, 2'b01));
        vt[9]  = mkv(8'h90, 8'hAB, 1'b0, 1'b1, 1'b1, mk(4'd4, 1'b1, 4'h0, 4'hA, 4'hB, 4'hA, 4'h6, 2'b00, 1'b0, 1'b0, 2'b00));
        vt[10] = mkv(8'hA0, 8'h12, 1'b0, 1'b1, 1'b1, mk(4'd4, 1'b1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h7, 2'b00, 1'b0, 1'b0, 2'b01));
        vt[11] = mkv(8'hB0, 8'hE1, 1'b1, 1'b1, 1'b1, mk(4'd4, 1'b1, 4'h0, 4'hE, 4'h0, 4'hE, 4'h8, 2'b00, 1'b0, 1'b0, 2'b01));
        vt[12] = mkv(8'hD0, 8'h34, 1'b0, 1'b1, 1'b1, mk(4'd4, 1'b1, 4'h0, 4'h3, 4'h4, 4'h3, 4'h9, 2'b00, 1'b0, 1'b0, 2'b00));
        vt[13] = mkv(8'hC6, 8'h00, 1'b0, 1'b0, 1'b1, mk(4'd6, 1'b0, 4'h0, 4'h6, 4'h0, 4'hF, 4'h1, 2'b00, 1'b0, 1'b1, 2'b00));
        vt[14] = mkv(8'hC6, 8'h00, 1'b1, 1'b0, 1'b0, o_zero(4'd0));
        vt[15] = mkv(8'hE9, 8'h00, 1'b1, 1'b0, 1'b1, mk(4'd6, 1'b0, 4'h0, 4'h9, 4'h0, 4'hF, 4'h1, 2'b00, 1'b0, 1'b1, 2'b00));
        vt[16] = mkv(8'hE9, 8'h00, 1'b0, 1'b0, 1'b0, o_zero(4'd0));

        @(negedge clk); check("reset", o_zero(4'd0));
        @(negedge clk); check("reset_hold", o_zero(4'd0));
        rst_n = 1'b1;
        @(negedge clk); check("idle_no_start", o_zero(4'd0));

        // start stays high through the table: it must be ignored while busy
        start = 1'b1;
        for (int i = 0; i < 17; i++) push_vec(vt[i]);
        run_queue("table");

        start = 1'b0;
        push(o_fetch(), 8'hF0, 1'b0, 1'b1);
        push(o_decode(), 8'hF0, 1'b0, 1'b1);
        push(o_zero(4'd7), 8'hF0, 1'b0, 1'b1);
        push(o_zero(4'd7), 8'hF0, 1'b0, 1'b1);
        run_queue("halt");

        start = 1'b1;
        push(o_fetch(), 8'h73, 1'b0, 1'b1);
        push(o_decode(), 8'h73, 1'b0, 1'b1);
        push(o_opnd(), 8'h25, 1'b0, 1'b1);
        run_queue("restart");

        // still mid-OPND: reset must clear everything before the next edge
        rst_n = 1'b0; start = 1'b0;
        #1 check("rst_mid_opnd", o_zero(4'd0));
        @(negedge clk); check("rst_held", o_zero(4'd0));
        rst_n = 1'b1;
        @(negedge clk); check("idle_after_rst", o_zero(4'd0));

`ifdef CTRL_MEM_HANDSHAKE_EN
        start = 1'b1;
        push(o_fetch(), 8'h24, 1'b0, 1'b1);
        push(o_decode(), 8'h24, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++)
            push(mk(4'd5, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b10, 1'b0, 1'b0, 2'b00), 8'h24, 1'b0, 1'b0);
        push(mk(4'd5, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b10, 1'b0, 1'b0, 2'b00), 8'h24, 1'b0, 1'b1);
        push(o_fetch(), 8'h24, 1'b0, 1'b0);
        push(mk(4'd1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b01, 1'b0, 1'b0, 2'b00), 8'h24, 1'b0, 1'b1);
        push(o_decode(), 8'h24, 1'b0, 1'b1);
        run_queue("mem_wait");
        start = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mcycle_ctrl.md
# mcycle_ctrl

Parametrised multicycle control unit for the image-downsampling processor. It sequences fetch, decode, operand-fetch, execute, memory and branch phases, and drives the datapath with register-select, ALU-op, memory and PC control. Compared with the existing control unit, it adds a `start`/`busy`/`done` run handshake, a latched opcode so two-word instructions survive the IR reload, both JPNZ and JPZ branches, a HALT state, and optional memory wait-state support.

## Interface
- `IW`, 8: instruction word width; must be even. Localparam `RSELW = IW/2`, the register-select field width.
- `ALUW`, 4: ALU opcode width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE or HALT.
- `instr`  in  IW  instruction-register contents.
- `z_flag`  in  1  ALU zero flag.
- `mem_ack`  in  1  memory completion; used only with `CTRL_MEM_HANDSHAKE_EN`.
- `busy`  out  1  high in every state except IDLE and HALT.
- `done`  out  1  high while in HALT.
- `pci`  out  1  PC increment.
- `rst_sel`  out  RSELW  register-clear select; 0 means none.
- `a_sel`, `b_sel`, `c_sel`  out  RSELW each  bus selects; 0 means none.
  - `c_sel = {RSELW{1'b1}}` selects PC.
  - `b_sel = {RSELW{1'b1}}` selects the MUX2 output.
- `alu_op`  out  ALUW  encoding: 0 none, 1 abus, 2 incr, 3 addi, 4 addr, 5 subi, 6 subr, 7 shl, 8 shr, 9 or.
- `mem_op`  out  2  encoding: 00 none, 01 im_read, 10 dm_read, 11 dm_write.
- `mem_req`  out  1  high whenever `mem_op` ≠ 00.
- `ir_en`  out  1  IR write enable.
- `branch`  out  1  branch strobe.
- `mux2_ctrl`  out  2  encoding: 00 none, 01 imm.
- `state`  out  4  present state code.

## Operation
- State codes:
  - IDLE 0, FETCH 1, DECODE 2, OPND 3, EXEC 4, MEM 5, BRANCH 6, HALT 7.
- Opcode is `instr[IW-1:RSELW]`; the operand field `r` is `instr[RSELW-1:0]`.
  - Opcodes: 0 NOOP, 1 CLR, 2 LOAD, 3 STORE, 4 COPY, 5 INCR, 6 ADDI, 7 ADDR, 8 SUBI, 9 SUBR, A SHL, B SHR, C JPNZ, D OR, E JPZ, F END.
- All outputs are Moore outputs: registered, valid for exactly the cycles `state` holds the corresponding value. Any unlisted output is 0.
- IDLE and HALT:
  - `start` = 1 → FETCH.
  - Otherwise the state is held.
- FETCH: `mem_op` = im_read, `ir_en` = 1 → DECODE.
- DECODE: `pci` = 1; the opcode is latched into an internal `op_q`. Next state by opcode:
  - Two-word opcodes (4, 6–B, D) → OPND.
  - CLR, INCR, NOOP → EXEC.
  - LOAD, STORE → MEM.
  - JPNZ → BRANCH if `z_flag` = 0, else FETCH.
  - JPZ → BRANCH if `z_flag` = 1, else FETCH.
  - END → HALT.
- OPND: `mem_op` = im_read, `ir_en` = 1 → EXEC. The IR now holds `d = instr[IW-1:RSELW]` and `s = instr[RSELW-1:0]`.
- EXEC: driven by `op_q`, then → FETCH.
  - CLR: `rst_sel = r`.
  - INCR: `a_sel = c_sel = r`, alu incr.
  - NOOP: nothing asserted.
  - Two-word opcodes additionally assert `pci` = 1.
  - COPY: `a_sel = s`, `c_sel = d`, abus.
  - ADDI/SUBI: `a_sel = c_sel = d`, `b_sel` = MUX2, `mux2_ctrl` = imm.
  - ADDR/SUBR/OR: `a_sel = c_sel = d`, `b_sel = s`.
  - SHL/SHR: `a_sel = c_sel = d`, `mux2_ctrl` = imm.
- MEM: `mem_op` = dm_read (LOAD) or dm_write (STORE) → FETCH.
- BRANCH: `a_sel = r`, `c_sel` = PC, alu abus, `branch` = 1 → FETCH.
- Boundary conditions:
  - `start` outside IDLE/HALT is ignored.
  - `rst_n` low in any state forces IDLE immediately; all outputs and `op_q` become 0.

## Timing
- Reset values: `state` = IDLE, and every output is 0, including `busy` and `done`.
- First FETCH occurs the cycle after `start` is sampled high.
- Cycle counts with no wait states:
  - CLR, INCR, NOOP, LOAD, STORE: 3 cycles.
  - Two-word ops: 4 cycles.
  - Branch taken: 3 cycles.
  - Branch not taken: 2 cycles.
  - END: 2 cycles to HALT.
- `z_flag` is sampled only on the DECODE cycle.

## Configuration
- `CTRL_MEM_HANDSHAKE_EN` defined:
  - FETCH, OPND and MEM hold state and outputs until `mem_ack` is sampled high.
  - In FETCH/OPND, `ir_en` = `mem_ack` (combinational AND with the state decode).
  - The state advances on the edge where `mem_ack` = 1.
  - `mem_ack` in other states is ignored.
- Not defined: `mem_ack` is unused; each of those states lasts exactly one cycle, with `ir_en` = 1 in FETCH/OPND.

## Test plan
- Reset with `start` = 0: all outputs 0, `state` = 0. `start` pulse → `state` sequence 1, 2; `busy` = 1 from FETCH onward.
- `instr` = 8'h73 then 8'h25 (ADDR R2,R5) → EXEC has `a_sel` = 2, `b_sel` = 5, `c_sel` = 2, `alu_op` = 4, `pci` = 1; 4 cycles total.
- `instr` = 8'hC6:
  - with `z_flag` = 0 → BRANCH with `a_sel` = 6, `c_sel` = 4'hF, `branch` = 1;
  - with `z_flag` = 1 → FETCH directly after DECODE.
- `instr` = 8'hF0 → HALT, `done` = 1, `busy` = 0; `start` then restarts at FETCH.
- With handshake enabled: LOAD with `mem_ack` delayed 3 cycles → MEM held 4 cycles with `mem_op` = 10 throughout; no IR write occurs.
- `rst_n` asserted mid-OPND → outputs 0 and `state` = 0 before the next clock edge.
